serial_subtractor: RTL and testbench

- Parametrised multi-cycle subtractor computing diff = a - b - bin over WIDTH bits.
- Processes DIGIT bits per clock, LSB first, with a registered borrow chain; generalises the single-bit full subtractor cell.
- Start/ready/done handshake.
- Reports unsigned borrow-out and signed overflow; used where area matters more than latency.

---
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Start/ready/done handshake; reports unsigned borrow-out and signed overflow.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             bint;
    logic [WIDTH-1:0] ra, rb, res, res_nx;
    logic             amsb, bmsb;
    logic [DIGIT-1:0] d;
    logic             bnext;
    logic             last;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                ready    = 1'b1;
                done     = 1'b1;
                accept   = start;
                state_nx = start ? CALC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands shift right so the current slice is always the low DIGIT bits.
    always_comb begin
        {bnext, d} = {1'b0, ra[DIGIT-1:0]} - {1'b0, rb[DIGIT-1:0]}
                   - (DIGIT+1)'(bint);
        res_nx = res >> DIGIT;
        res_nx[WIDTH-1 -: DIGIT] = d;
        last = (N == 1) ? 1'b1 : (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            bint     <= 1'b0;
            ra       <= '0;
            rb       <= '0;
            res      <= '0;
            amsb     <= 1'b0;
            bmsb     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            bint <= bin;
            ra   <= a;
            rb   <= b;
            amsb <= a[WIDTH-1];
            bmsb <= b[WIDTH-1];
        end else if (state == CALC) begin
            ra   <= ra >> DIGIT;
            rb   <= rb >> DIGIT;
            res  <= res_nx;
            bint <= bnext;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff     <= res_nx;
                borrow   <= bnext;
                overflow <= (amsb != bmsb) && (d[DIGIT-1] != amsb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor in three configurations:
// WIDTH=1/DIGIT=1, WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s1_start, s1_a, s1_b, s1_bin;
    logic       s1_ready, s1_busy, s1_done, s1_diff, s1_borrow, s1_ovf;
    logic       s8_start, s8_bin;
    logic [7:0] s8_a, s8_b, s8_diff;
    logic       s8_ready, s8_busy, s8_done, s8_borrow, s8_ovf;
    logic       s4_start, s4_bin;
    logic [7:0] s4_a, s4_b, s4_diff;
    logic       s4_ready, s4_busy, s4_done, s4_borrow, s4_ovf;

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start),
        .a(s1_a), .b(s1_b), .bin(s1_bin),
        .ready(s1_ready), .busy(s1_busy), .done(s1_done),
        .diff(s1_diff), .borrow(s1_borrow), .overflow(s1_ovf)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start),
        .a(s8_a), .b(s8_b), .bin(s8_bin),
        .ready(s8_ready), .busy(s8_busy), .done(s8_done),
        .diff(s8_diff), .borrow(s8_borrow), .overflow(s8_ovf)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
        .a(s4_a), .b(s4_b), .bin(s4_bin),
        .ready(s4_ready), .busy(s4_busy), .done(s4_done),
        .diff(s4_diff), .borrow(s4_borrow), .overflow(s4_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t v8[6];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Launch on the D1 instance; returns #1 after the accepting edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
        s8_a = a; s8_b = b; s8_bin = bi; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
    endtask

    // Wait k edges; done must be low until the k-th, then results checked.
    task automatic wait8(input int k, input string nm, input logic [7:0] d,
                         input logic bo, input logic ov);
        for (int i = 1; i < k; i++) begin
            @(posedge clk); #1;
            chk({nm, " early_done"}, 32'(s8_done), 32'd0);
        end
        @(posedge clk); #1;
        chk({nm, " done"}, 32'(s8_done), 32'd1);
        chk({nm, " diff"}, 32'(s8_diff), 32'(d));
        chk({nm, " borrow"}, 32'(s8_borrow), 32'(bo));
        chk({nm, " ovf"}, 32'(s8_ovf), 32'(ov));
    endtask

    initial begin
        v8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        v8[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        v8[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        v8[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        v8[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        v8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        s1_start = 0; s1_a = 0; s1_b = 0; s1_bin = 0;
        s8_start = 0; s8_a = 0; s8_b = 0; s8_bin = 0;
        s4_start = 0; s4_a = 0; s4_b = 0; s4_bin = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst ready", {s1_ready, s8_ready, s4_ready}, 32'h7);
        chk("rst busy", {s1_busy, s8_busy, s4_busy}, 32'h0);
        chk("rst done", {s1_done, s8_done, s4_done}, 32'h0);
        chk("rst diff8", {s8_diff, s4_diff}, 32'h0);
        chk("rst flags", {s1_diff, s1_borrow, s1_ovf, s8_borrow,
                          s8_ovf, s4_borrow, s4_ovf}, 32'h0);

        // Registered full subtractor, all 8 input combinations.
        for (int i = 0; i < 8; i++) begin
            int ia, ib, ic, sv;
            logic eb, eo;
            ia = (i >> 2) & 1; ib = (i >> 1) & 1; ic = i & 1;
            eb = (ia < ib + ic);
            sv = (ia ? -1 : 0) - (ib ? -1 : 0) - ic;
            eo = (sv < -1) || (sv > 0);
            s1_a = ia[0]; s1_b = ib[0]; s1_bin = ic[0]; s1_start = 1'b1;
            @(posedge clk); #1;
            s1_start = 1'b0;
            chk($sformatf("w1[%0d] busy", i), 32'(s1_busy), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("w1[%0d] done", i), 32'(s1_done), 32'd1);
            chk($sformatf("w1[%0d] diff", i), 32'(s1_diff),
                32'((ia + 2 - ib - ic) & 1));
            chk($sformatf("w1[%0d] borrow", i), 32'(s1_borrow), 32'(eb));
            chk($sformatf("w1[%0d] ovf", i), 32'(s1_ovf), 32'(eo));
        end

        // WIDTH=8, DIGIT=1 table.
        for (int i = 0; i < 6; i++) begin
            go8(v8[i].a, v8[i].b, v8[i].bin);
            wait8(8, $sformatf("w8[%0d]", i), v8[i].d, v8[i].bo, v8[i].ov);
        end
        @(posedge clk); #1;
        chk("w8 done_pulse", 32'(s8_done), 32'd0);
        chk("w8 idle_ready", 32'(s8_ready), 32'd1);

        // WIDTH=8, DIGIT=4 with back-to-back start in the DONE cycle.
        s4_a = 8'h3C; s4_b = 8'hC3; s4_bin = 1'b0; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        @(posedge clk); #1;
        chk("d4 early_done", 32'(s4_done), 32'd0);
        @(posedge clk); #1;
        chk("d4 done", 32'(s4_done), 32'd1);
        chk("d4 diff", 32'(s4_diff), 32'h79);
        chk("d4 borrow", 32'(s4_borrow), 32'd1);
        chk("d4 ovf", 32'(s4_ovf), 32'd0);
        chk("d4 ready_in_done", 32'(s4_ready), 32'd1);
        s4_a = 8'h01; s4_b = 8'h01; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        chk("d4b busy", 32'(s4_busy), 32'd1);
        @(posedge clk); #1;
        chk("d4b early_done", 32'(s4_done), 32'd0);
        @(posedge clk); #1;
        chk("d4b done", 32'(s4_done), 32'd1);
        chk("d4b diff", 32'(s4_diff), 32'h00);
        chk("d4b borrow", 32'(s4_borrow), 32'd0);

        // Start pulse and operand change while busy are ignored.
        go8(8'h05, 8'h03, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        s8_a = 8'hAA; s8_b = 8'h55; s8_start = 1'b1;
        chk("busy ready", 32'(s8_ready), 32'd0);
        chk("busy busy", 32'(s8_busy), 32'd1);
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait8(5, "ign", 8'h02, 1'b0, 1'b0);

        // Reset in the third CALC cycle discards the operation.
        @(posedge clk); #1;
        go8(8'h80, 8'h01, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst done", 32'(s8_done), 32'd0);
        chk("mid_rst ready", 32'(s8_ready), 32'd1);
        chk("mid_rst busy", 32'(s8_busy), 32'd0);
        chk("mid_rst outs", {s8_diff, s8_borrow, s8_ovf}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst[%0d] done", i), 32'(s8_done), 32'd0);
        end
        go8(8'h7F, 8'hFF, 1'b0);
        wait8(8, "after_rst", 8'h80, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
